// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reset values and the fetch-stage state encoding.
package cpu_pkg;

   localparam logic [3:0]  OP_NOP       = 4'h0;
   localparam logic [3:0]  OP_HLT       = 4'hF;

   localparam logic [15:0] CPU_RESET_PC = 16'h0000;
   localparam logic [15:0] CPU_BUBBLE   = {OP_NOP, 12'h000};

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StHalt
   } fetch_state_e;

   // Instruction words are 16 bits, so the PC steps by 2 and wraps at 2^16.
   function automatic logic [15:0] pc_inc(input logic [15:0] addr);
      return addr + 16'd2;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, pc} holding register with load/unload/flush and a full flag.
module fetch_skid_buf
   import cpu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        flush_i,
   input  logic [15:0] instr_i,
   input  logic [15:0] pc_i,
   output logic        full_o,
   output logic [15:0] instr_o,
   output logic [15:0] pc_o
);

   logic        full_q, full_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_q, pc_d;

   // Flush wins over load so a redirect can never leave a stale entry behind.
   always_comb begin
      full_d  = full_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d  = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (unload_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q  <= 1'b0;
         instr_q <= CPU_BUBBLE;
         pc_q    <= CPU_RESET_PC;
      end else begin
         full_q  <= full_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/mod_if_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/rdy, feeds decode through a skid buffer.
module mod_if_fetch
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = CPU_RESET_PC,
   parameter logic [3:0]  HLT_OPCODE = OP_HLT,
   parameter logic [15:0] BUBBLE     = CPU_BUBBLE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] instruction,
   output logic [15:0] pc,
   output logic        valid,
   output logic        halted
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic         req_q, req_d;
   logic [15:0]  addr_q, addr_d;
   logic [15:0]  instr_q, instr_d;
   logic [15:0]  pc_out_q, pc_out_d;
   logic         valid_q, valid_d;

   logic         skid_load, skid_unload, skid_flush, skid_full, skid_full_nxt;
   logic [15:0]  skid_instr, skid_pc;
   logic         fire, run_fire, pending, take;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      valid_d     = valid_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = 1'b0;

      fire     = req_q & imem_rdy;
      run_fire = fire & (state_q == StRun);
      pending  = req_q & ~imem_rdy;
      take     = ~valid_q | ~stall;

      if (redirect) begin
         pc_d       = redirect_pc & 16'hFFFE;
         valid_d    = 1'b0;
         instr_d    = BUBBLE;
         skid_flush = 1'b1;
         state_d    = pending ? StDrain : StRun;
      end else begin
         if (state_q == StDrain && fire) begin
            state_d = StRun;
         end
         if (run_fire) begin
            // A HLT leaves the PC pointing at itself.
            if (imem_data[15:12] == HLT_OPCODE) begin
               state_d = StHalt;
            end else begin
               pc_d = pc_inc(pc_q);
            end
         end
         if (take) begin
            if (skid_full) begin
               instr_d     = skid_instr;
               pc_out_d    = skid_pc;
               valid_d     = 1'b1;
               skid_unload = 1'b1;
            end else if (run_fire) begin
               instr_d  = imem_data;
               pc_out_d = pc_inc(addr_q);
               valid_d  = 1'b1;
            end else begin
               instr_d = BUBBLE;
               valid_d = 1'b0;
            end
         end else if (run_fire) begin
            skid_load = 1'b1;
         end
      end

      skid_full_nxt = skid_load | (skid_full & ~skid_unload & ~skid_flush);
      // An outstanding request is never withdrawn and its address is frozen until rdy.
      req_d  = pending | ((state_d == StRun) & ~skid_full_nxt);
      addr_d = pending ? addr_q : pc_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StRun;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         instr_q  <= BUBBLE;
         pc_out_q <= RESET_PC;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk_i    (clk),
      .rst_ni   (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .flush_i  (skid_flush),
      .instr_i  (imem_data),
      .pc_i     (pc_inc(addr_q)),
      .full_o   (skid_full),
      .instr_o  (skid_instr),
      .pc_o     (skid_pc)
   );

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instruction = instr_q;
   assign pc          = pc_out_q;
   assign valid       = valid_q;
   assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_mod_if_fetch.sv
// Bench for mod_if_fetch: directed scenarios plus random rdy/stall/redirect against an in-order stream model.
module tb_mod_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy = 1'b0;
   logic [15:0] imem_data;
   logic [15:0] instruction;
   logic [15:0] pc;
   logic        valid;
   logic        halted;

   logic [15:0] hlt_addr = 16'hFFFF;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_consumed = 0;
   logic [15:0] exp_next = 16'h0000;
   bit          exp_halt = 1'b0;

   always #5 clk = ~clk;

   // Memory contents: addr ^ A5A5, except a planted HLT word at hlt_addr.
   assign imem_data = (imem_addr == hlt_addr) ? 16'hF000 : (imem_addr ^ 16'hA5A5);

   mod_if_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_data   (imem_data),
      .instruction (instruction),
      .pc          (pc),
      .valid       (valid),
      .halted      (halted)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a == hlt_addr) ? 16'hF000 : (a ^ 16'hA5A5);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_restart(input logic [15:0] start);
      exp_next = start & 16'hFFFE;
      exp_halt = 1'b0;
   endtask

   // One clock: score any word decode consumes at this edge, check request stability across it.
   task automatic tick();
      logic        was_pending;
      logic [15:0] held_addr;
      logic [15:0] w;
      was_pending = imem_req & ~imem_rdy;
      held_addr   = imem_addr;
      if (valid && !stall && !redirect) begin
         if (exp_halt) begin
            chk("word_after_hlt", {15'b0, valid}, 16'h0000);
         end else begin
            w = mem_word(exp_next);
            chk("stream_instr", instruction, w);
            chk("stream_pc", pc, exp_next + 16'd2);
            n_consumed++;
            if (w[15:12] == 4'hF) exp_halt = 1'b1;
            else exp_next = exp_next + 16'd2;
         end
      end
      @(posedge clk);
      #1;
      if (was_pending && rst) begin
         chk("req_held", {15'b0, imem_req}, 16'h0001);
         chk("addr_held", imem_addr, held_addr);
      end
   endtask

   initial begin
      int budget;
      int start_cnt;
      logic [15:0] rpc;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_req", {15'b0, imem_req}, 16'h0000);
      chk("rst_valid", {15'b0, valid}, 16'h0000);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_halted", {15'b0, halted}, 16'h0000);

      // Streaming with rdy held high
      rst = 1'b1;
      model_restart(16'h0000);
      imem_rdy = 1'b1;
      tick();
      chk("t1_req0", {15'b0, imem_req}, 16'h0001);
      chk("t1_addr0", imem_addr, 16'h0000);
      chk("t1_valid0", {15'b0, valid}, 16'h0000);
      tick();
      chk("t1_addr1", imem_addr, 16'h0002);
      chk("t1_instr1", instruction, 16'hA5A5);
      chk("t1_pc1", pc, 16'h0002);
      tick();
      chk("t1_addr2", imem_addr, 16'h0004);
      chk("t1_pc2", pc, 16'h0004);
      tick();
      chk("t2_pc_pre", pc, 16'h0006);

      // Stall three cycles; 0006 goes into the skid, requests stop
      start_cnt = n_consumed;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_pc", pc, 16'h0006);
         chk("t2_hold_instr", instruction, 16'h0004 ^ 16'hA5A5);
         chk("t2_req_off", {15'b0, imem_req}, 16'h0000);
      end
      stall = 1'b0;
      tick();
      chk("t2_skid_pc", pc, 16'h0008);
      chk("t2_req_on", imem_addr, 16'h0008);
      tick();
      chk("t2_next_pc", pc, 16'h000A);
      chk("t2_count", 16'(n_consumed - start_cnt), 16'd2);

      // Redirect while a request to 0010 is stuck waiting
      budget = 20;
      while (imem_addr != 16'h0010 && budget > 0) begin
         tick();
         budget--;
      end
      chk("t3_reach_0010", imem_addr, 16'h0010);
      imem_rdy = 1'b0;
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 16'h0101;
      tick();
      redirect = 1'b0;
      model_restart(16'h0100);
      chk("t3_valid_off", {15'b0, valid}, 16'h0000);
      chk("t3_bubble", instruction, 16'h0000);
      imem_rdy = 1'b1;
      tick();
      chk("t3_valid_drop", {15'b0, valid}, 16'h0000);
      chk("t3_new_addr", imem_addr, 16'h0100);
      tick();
      chk("t3_instr", instruction, 16'h0100 ^ 16'hA5A5);
      chk("t3_pc", pc, 16'h0102);

      // HLT at 0006
      rst = 1'b0;
      #2;
      rst = 1'b1;
      hlt_addr = 16'h0006;
      model_restart(16'h0000);
      tick();
      budget = 12;
      while (!(valid && instruction == 16'hF000) && budget > 0) begin
         tick();
         budget--;
      end
      chk("t4_hlt_instr", instruction, 16'hF000);
      chk("t4_hlt_pc", pc, 16'h0008);
      chk("t4_halted", {15'b0, halted}, 16'h0001);
      tick();
      tick();
      chk("t4_req_off", {15'b0, imem_req}, 16'h0000);
      chk("t4_addr_stay", imem_addr, 16'h0006);
      chk("t4_still_halted", {15'b0, halted}, 16'h0001);
      redirect = 1'b1;
      redirect_pc = 16'h0020;
      tick();
      redirect = 1'b0;
      model_restart(16'h0020);
      chk("t4_unhalt", {15'b0, halted}, 16'h0000);
      chk("t4_req_0020", imem_addr, 16'h0020);
      tick();
      chk("t4_pc_0022", pc, 16'h0022);
      hlt_addr = 16'hFFFF;

      // Wrap at FFFE (bit 0 of redirect_pc ignored)
      redirect = 1'b1;
      redirect_pc = 16'hFFFF;
      tick();
      redirect = 1'b0;
      model_restart(16'hFFFE);
      chk("t5_addr_fffe", imem_addr, 16'hFFFE);
      tick();
      chk("t5_pc_wrap", pc, 16'h0000);
      chk("t5_instr", instruction, 16'hFFFE ^ 16'hA5A5);
      chk("t5_addr_wrap", imem_addr, 16'h0000);

      // Random rdy / stall / redirect
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      tick();
      redirect = 1'b0;
      model_restart(16'h0200);
      start_cnt = n_consumed;
      for (int i = 0; i < 300; i++) begin
         imem_rdy = 1'($urandom_range(0, 1));
         stall = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 24) == 0);
         rpc = {4'h0, 12'($urandom)};
         redirect_pc = rpc;
         tick();
         if (redirect) model_restart(rpc);
      end
      redirect = 1'b0;
      stall = 1'b0;
      chk("rand_progress", {15'b0, (n_consumed - start_cnt) > 20}, 16'h0001);

      // Asynchronous reset between edges with a request pending
      imem_rdy = 1'b0;
      budget = 10;
      while (!imem_req && budget > 0) begin
         tick();
         budget--;
      end
      chk("t6_req_pending", {15'b0, imem_req}, 16'h0001);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_req_async", {15'b0, imem_req}, 16'h0000);
      chk("t6_valid_async", {15'b0, valid}, 16'h0000);
      chk("t6_pc_async", pc, 16'h0000);
      imem_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_req_in_rst", {15'b0, imem_req}, 16'h0000);
      #2;
      rst = 1'b1;
      model_restart(16'h0000);
      tick();
      chk("t6_restart_addr", imem_addr, 16'h0000);
      chk("t6_restart_req", {15'b0, imem_req}, 16'h0001);
      tick();
      chk("t6_restart_pc", pc, 16'h0002);
      chk("t6_restart_instr", instruction, 16'hA5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
